// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle for instr_encoder.
//   master : instruction-injection source and fetch-side consumer
//            (drives request fields and out_ready, observes status)
//   slave  : the encoder itself
// Signals:
//   in_valid/in_ready    request handshake
//   in_fmt .. in_imm     decoded instruction fields
//   out_valid/out_ready  FIFO head handshake
//   out_instr/out_err    encoded word and range-error flag at head
//   err_cnt              saturating count of accepted erroneous requests
interface instr_encoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word
// and buffers {word, err} in a DEPTH-entry FIFO.
// Optional immediate range checking is enabled by defining
// INSTR_ENC_IMM_CHECK_EN; without it only illegal formats set err.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_encoder_if.slave (request fields, FIFO head, err_cnt)
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  err_cnt width
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        range_err;
  logic        is_shift;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [32:0]   head;
  logic          push;
  logic          pop;

  // Immediate shifts carry shamt in imm[4:0] and funct7 in the top bits.
  assign is_shift = (bus.in_opcode == 7'b0010011) &&
                    ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  always_comb begin
    enc_instr = '0;
    case (bus.in_fmt)
      FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      FMT_I: begin
        if (is_shift)
          enc_instr = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                       bus.in_rd, bus.in_opcode};
        else
          enc_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                       bus.in_rd, bus.in_opcode};
      end
      FMT_S: enc_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_imm[4:0], bus.in_opcode};
      FMT_B: enc_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11],
                          bus.in_opcode};
      FMT_U: enc_instr = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      FMT_J: enc_instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                          bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
      default: enc_instr = {25'b0, bus.in_opcode};
    endcase
  end

  // A value fits a sign-extended field when all bits above the field
  // are copies of its sign bit (all ones or all zeros).
  always_comb begin
    range_err = 1'b0;
`ifdef INSTR_ENC_IMM_CHECK_EN
    case (bus.in_fmt)
      FMT_I: begin
        if (is_shift)
          range_err = |bus.in_imm[31:5];
        else
          range_err = ~((&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]));
      end
      FMT_S: range_err = ~((&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]));
      FMT_B: range_err = ~((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12])) |
                         bus.in_imm[0];
      FMT_U: range_err = |bus.in_imm[11:0];
      FMT_J: range_err = ~((&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20])) |
                         bus.in_imm[0];
      default: range_err = 1'b0;
    endcase
`else
    range_err = 1'b0;
`endif
  end

  assign enc_err = (bus.in_fmt > FMT_J) | range_err;

  // in_ready looks only at the registered count, so a pop while full
  // never opens a slot in the same cycle.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign head          = mem[rd_ptr];
  // Storage is not reset; gating keeps the head fields at zero while empty.
  assign bus.out_instr = bus.out_valid ? head[32:1] : 32'h0;
  assign bus.out_err   = bus.out_valid & head[0];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {enc_instr, enc_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.err_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (push && enc_err && (bus.err_cnt != {CNT_W{1'b1}}))
        bus.err_cnt <= bus.err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder
// against a field-arithmetic reference model and a queue scoreboard.
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

`ifdef INSTR_ENC_IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [32:0] q[$];
  int          mcnt = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference encoder: places each immediate slice by plain arithmetic and
  // judges range by the numeric value the field can represent.
  function automatic logic [32:0] model_enc(
    input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [31:0] imm);
    longint unsigned u, w, c, OP, F7, RD, RS2;
    longint s;
    bit e, sh;
    u   = imm;
    s   = $signed(imm);
    OP  = op;  F7 = f7;  RD = rd;  RS2 = rs2;
    c   = (longint'(rs1) << 15) | (longint'(f3) << 12) | OP;
    sh  = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
    e   = 0;
    case (fmt)
      3'd0: w = (F7 << 25) | (RS2 << 20) | (RD << 7) | c;
      3'd1: begin
        if (sh) begin
          w = (F7 << 25) | ((u % 32) << 20) | (RD << 7) | c;
          e = (u >= 32);
        end else begin
          w = ((u % 4096) << 20) | (RD << 7) | c;
          e = (s < -2048) || (s > 2047);
        end
      end
      3'd2: begin
        w = (((u / 32) % 128) << 25) | (RS2 << 20) | ((u % 32) << 7) | c;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) % 64) << 25) | (RS2 << 20) |
            (((u >> 1) % 16) << 8) | (((u >> 11) & 1) << 7) | c;
        e = (s < -4096) || (s > 4095) || (u % 2 == 1);
      end
      3'd4: begin
        w = ((u / 4096) << 12) | (RD << 7) | OP;
        e = (u % 4096) != 0;
      end
      3'd5: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) % 1024) << 21) |
            (((u >> 11) & 1) << 20) | (((u >> 12) % 256) << 12) | (RD << 7) | OP;
        e = (s < -(1 << 20)) || (s >= (1 << 20)) || (u % 2 == 1);
      end
      default: begin
        w = OP;
        e = 1;
      end
    endcase
    if (!CHK && fmt <= 3'd5) e = 0;
    return {w[31:0], e};
  endfunction

  task automatic set_req(input logic v, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid  = v;   bus.in_fmt  = fmt; bus.in_opcode = op;
    bus.in_funct3 = f3;  bus.in_funct7 = f7;
    bus.in_rd     = rd;  bus.in_rs1 = rs1;  bus.in_rs2 = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic rand_req(input logic v);
    logic [31:0] imm;
    logic [6:0]  op;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($signed($urandom_range(0, 12000)) - 6000);
      2: imm = $urandom & 32'hFFFFF000;
      default: imm = $urandom_range(0, 40);
    endcase
    op = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'($urandom);
    set_req(v, 3'($urandom), op, 3'($urandom), 7'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), imm);
  endtask

  // One clock: check outputs against the scoreboard, predict the
  // handshakes, advance, then update the scoreboard.
  task automatic cycle();
    bit          do_push, do_pop;
    logic [32:0] e;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_instr", bus.out_instr, q[0][32:1]);
      chk("out_err", 32'(bus.out_err), 32'(q[0][0]));
    end
    chk("err_cnt", 32'(bus.err_cnt), 32'(mcnt));
    do_push = bus.in_valid && (q.size() != DEPTH);
    do_pop  = bus.out_ready && (q.size() != 0);
    e = model_enc(bus.in_fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7,
                  bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    @(posedge clk);
    #1;
    if (do_pop)  void'(q.pop_front());
    if (do_push) begin
      q.push_back(e);
      if (e[0] && mcnt != 255) mcnt++;
    end
  endtask

  task automatic vec(input string name, input logic [2:0] fmt, input logic [6:0] op,
                     input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] exp_w, input logic exp_e);
    bus.out_ready = 1'b0;
    set_req(1'b1, fmt, op, f3, 7'd0, rd, rs1, rs2, imm);
    cycle();
    bus.in_valid = 1'b0;
    chk({name, "_word"}, bus.out_instr, exp_w);
    chk({name, "_err"}, 32'(bus.out_err), 32'(exp_e));
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    rst_n = 1'b1;
    cycle();

    vec("addi", 3'd1, 7'b0010011, 3'b000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    vec("sw",   3'd2, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8,        32'h00512423, 1'b0);
    vec("beq",  3'd3, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    vec("jal",  3'd5, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0);
    vec("lui",  3'd4, 7'b0110111, 3'b000, 5'd3, 5'd0, 5'd0, 32'h12345000, 32'h123451B7, 1'b0);
    vec("rng",  3'd1, 7'b0010011, 3'b000, 5'd1, 5'd2, 5'd0, 32'd2048,     32'h80010093, CHK);
    chk("rng_err_cnt", 32'(bus.err_cnt), CHK ? 32'd1 : 32'd0);

    // Back-pressure: A, B fill the FIFO, C waits for a slot.
    bus.out_ready = 1'b0;
    set_req(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd100);
    cycle();
    set_req(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd200);
    cycle();
    set_req(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 32'd300);
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    cycle();
    chk("bp_head_a", bus.out_instr, 32'h06408093);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_head_b", bus.out_instr, 32'h0C810113);
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_head_c", bus.out_instr, 32'h12C18193);
    cycle();
    cycle();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Streaming: one word per cycle, occupancy stays at one.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 3'd1, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd4, 5'd0, 32'(i * 7 + 1));
      cycle();
      chk("stream_one", 32'(q.size()), 32'd1);
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("stream_empty", 32'(bus.out_valid), 32'd0);

    // Illegal format and err_cnt saturation.
    vec("illegal", 3'd7, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
    bus.out_ready = 1'b1;
    set_req(1'b1, 3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 300; i++) cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    // Reset between edges with two words buffered.
    bus.out_ready = 1'b0;
    rand_req(1'b1);
    cycle();
    rand_req(1'b1);
    cycle();
    bus.in_valid = 1'b0;
    chk("mid_full", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_out_instr", bus.out_instr, 32'd0);
    chk("mid_out_err", 32'(bus.out_err), 32'd0);
    chk("mid_err_cnt", 32'(bus.err_cnt), 32'd0);
    q.delete();
    mcnt = 0;
    #1;
    rst_n = 1'b1;
    cycle();
    set_req(1'b1, 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000);
    cycle();
    bus.in_valid = 1'b0;
    chk("post_rst_word", bus.out_instr, 32'hABCDE4B7);
    bus.out_ready = 1'b1;
    cycle();
    chk("post_rst_alone", 32'(bus.out_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_req($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("final_empty", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
